// File: rtl/count_serializer_if.sv
// count_serializer_if: request/status and 3-wire serial link between the counter stage and the serializer.
interface count_serializer_if #(parameter int WIDTH = 8);
    logic             start;
    logic             data_valid;
    logic [WIDTH-1:0] data_in;
    logic             clr_ovr;
    logic             cs_n;
    logic             sclk;
    logic             sdo;
    logic             busy;
    logic             done;
    logic             ovr;
    modport master (output start, data_valid, data_in, clr_ovr,
                    input  cs_n, sclk, sdo, busy, done, ovr);
    modport slave  (input  start, data_valid, data_in, clr_ovr,
                    output cs_n, sclk, sdo, busy, done, ovr);
endinterface

// File: rtl/count_serializer.sv
// count_serializer: snapshots the counter value and shifts it out SPI mode 0 with busy/done/overrun status.
module count_serializer #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 2,
    parameter bit MSB_FIRST = 1
) (
    input logic clk,
    input logic rst_n,
    count_serializer_if.slave bus
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    state_t           state, state_n;
    logic [7:0]       div, div_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sh, sh_n, nxt;
    logic             cs_n_q, sclk_q, sdo_q, busy_q, done_q, ovr_q;
    logic             cs_n_n, sclk_n, sdo_n, busy_n, done_n, ovr_n;
    logic             hit;
    assign hit = div == 8'(DIV - 1);
    assign nxt = MSB_FIRST ? sh << 1 : sh >> 1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            div    <= '0;
            cnt    <= '0;
            sh     <= '0;
            cs_n_q <= 1'b1;
            sclk_q <= 1'b0;
            sdo_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            state  <= state_n;
            div    <= div_n;
            cnt    <= cnt_n;
            sh     <= sh_n;
            cs_n_q <= cs_n_n;
            sclk_q <= sclk_n;
            sdo_q  <= sdo_n;
            busy_q <= busy_n;
            done_q <= done_n;
            ovr_q  <= ovr_n;
        end
    end
    // A drop while busy outranks a simultaneous clear.
    always_comb begin
        state_n = state;
        div_n   = div;
        cnt_n   = cnt;
        sh_n    = sh;
        cs_n_n  = cs_n_q;
        sclk_n  = sclk_q;
        sdo_n   = sdo_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        ovr_n   = (bus.start & busy_q) | (ovr_q & ~bus.clr_ovr);
        case (state)
            IDLE: if (bus.start && bus.data_valid) begin
                state_n = SHIFT;
                sh_n    = bus.data_in;
                sdo_n   = MSB_FIRST ? bus.data_in[WIDTH-1] : bus.data_in[0];
                cs_n_n  = 1'b0;
                busy_n  = 1'b1;
                div_n   = '0;
                cnt_n   = '0;
                sclk_n  = 1'b0;
            end
            SHIFT: begin
                div_n = hit ? 8'd0 : div + 8'd1;
                if (hit) begin
                    sclk_n = ~sclk_q;
                    // Falling edge: either move to the next bit or close the frame.
                    if (sclk_q && cnt == CW'(WIDTH - 1)) begin
                        state_n = GAP;
                        cs_n_n  = 1'b1;
                        sdo_n   = 1'b0;
                    end else if (sclk_q) begin
                        cnt_n = cnt + 1'b1;
                        sh_n  = nxt;
                        sdo_n = MSB_FIRST ? nxt[WIDTH-1] : nxt[0];
                    end
                end
            end
            GAP: begin
                div_n = hit ? 8'd0 : div + 8'd1;
                if (hit) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    assign bus.cs_n = cs_n_q;
    assign bus.sclk = sclk_q;
    assign bus.sdo  = sdo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.ovr  = ovr_q;
endmodule

// File: tb/tb_count_serializer.sv
// tb_count_serializer: directed checks of frame timing, bit order, overrun and reset for three configurations.
module tb_count_serializer;
    logic       clk = 0, rst_n = 0, start = 0, dv = 0, clr = 0;
    logic [7:0] din = 0;
    int         checks = 0, errors = 0, sel = 0;
    logic       cs_n, sclk, sdo, busy, done, ovr;
    always #5 clk = ~clk;
    count_serializer_if #(.WIDTH(8)) ia(), ib(), ic();
    assign ia.start = start; assign ia.data_valid = dv; assign ia.data_in = din; assign ia.clr_ovr = clr;
    assign ib.start = start; assign ib.data_valid = dv; assign ib.data_in = din; assign ib.clr_ovr = clr;
    assign ic.start = start; assign ic.data_valid = dv; assign ic.data_in = din; assign ic.clr_ovr = clr;
    count_serializer #(.WIDTH(8), .DIV(2), .MSB_FIRST(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    count_serializer #(.WIDTH(8), .DIV(2), .MSB_FIRST(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    count_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));
    always_comb
        {cs_n, sclk, sdo, busy, done, ovr} = sel == 0 ? {ia.cs_n, ia.sclk, ia.sdo, ia.busy, ia.done, ia.ovr} :
                                             sel == 1 ? {ib.cs_n, ib.sclk, ib.sdo, ib.busy, ib.done, ib.ovr} :
                                                        {ic.cs_n, ic.sclk, ic.sdo, ic.busy, ic.done, ic.ovr};
    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end
    task automatic settle();
        int n = 0;
        @(negedge clk);
        start = 0;
        dv = 0;
        while ((ia.busy | ib.busy | ic.busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((ia.busy | ib.busy | ic.busy) !== 1'b0) begin
            errors++;
            $display("FAIL settle busy=1 required 0");
        end
        clr = 1;
        @(negedge clk);
        clr = 0;
    endtask
    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if ({cs_n, sclk, sdo, busy, done, ovr} !== 6'b100000) begin
                errors++;
                $display("FAIL reset dut%0d outs=%b required 100000", s, {cs_n, sclk, sdo, busy, done, ovr});
            end
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask
    // Runs one accepted frame; xs = cycle of an extra (dropped) start, xc = cycle of clr_ovr.
    task automatic frame(input int s, input logic [7:0] d, input logic [7:0] exp, input int dvv,
                         input int xs, input int xc, input string nm);
        logic [7:0] seq = 0;
        int         rises = 0;
        logic       ps = 0;
        int         last = (17 * dvv + 2 > xc + 2) ? 17 * dvv + 2 : xc + 2;
        sel = s;
        @(negedge clk);
        din = d;
        dv = 1;
        start = 1;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (sclk && !ps) begin
                seq = {seq[6:0], sdo};
                rises++;
            end
            ps = sclk;
            checks++;
            if (cs_n !== 1'(k > 16 * dvv)) begin
                errors++;
                $display("FAIL %s cs_n k=%0d got %b required %b", nm, k, cs_n, 1'(k > 16 * dvv));
            end
            checks++;
            if (busy !== 1'(k <= 17 * dvv)) begin
                errors++;
                $display("FAIL %s busy k=%0d got %b required %b", nm, k, busy, 1'(k <= 17 * dvv));
            end
            checks++;
            if (done !== 1'(k == 17 * dvv + 1)) begin
                errors++;
                $display("FAIL %s done k=%0d got %b required %b", nm, k, done, 1'(k == 17 * dvv + 1));
            end
            if (xs > 0) begin
                checks++;
                if (ovr !== 1'(k > xs && k <= xc)) begin
                    errors++;
                    $display("FAIL %s ovr k=%0d got %b required %b", nm, k, ovr, 1'(k > xs && k <= xc));
                end
            end
            start = (k == xs);
            dv = (k == xs);
            clr = (k == xc);
            din = ~d;
        end
        start = 0;
        dv = 0;
        clr = 0;
        checks++;
        if (seq !== exp || rises != 8) begin
            errors++;
            $display("FAIL %s bits got %h (%0d rises) required %h (8 rises)", nm, seq, rises, exp);
        end
    endtask
    task automatic test_invalid();
        logic v;
        @(negedge clk);
        start = 1;
        dv = 0;
        din = 8'hFF;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            v = ia.busy | ib.busy | ic.busy | ia.ovr | ib.ovr | ic.ovr | ~ia.cs_n | ~ib.cs_n | ~ic.cs_n;
            checks++;
            if (v !== 1'b0) begin
                errors++;
                $display("FAIL invalid k=%0d activity=%b required 0", k, v);
            end
        end
        start = 0;
    endtask
    task automatic test_back_to_back();
        int dk = -5, nd = 0;
        sel = 2;
        @(negedge clk);
        din = 8'h5A;
        start = 1;
        dv = 1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == dk + 1) begin
                checks++;
                if (cs_n !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b cs_n k=%0d got %b required 0", k, cs_n);
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (cs_n !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b done_cs_n k=%0d got %b required 1", k, cs_n);
                end
                dk = k;
                nd++;
            end
        end
        checks++;
        if (nd != 3 || dk != 54) begin
            errors++;
            $display("FAIL b2b dones got %0d last %0d required 3 last 54", nd, dk);
        end
        checks++;
        if (ovr !== 1'b1) begin
            errors++;
            $display("FAIL b2b ovr got %b required 1", ovr);
        end
        settle();
    endtask
    task automatic test_reset_mid();
        sel = 0;
        @(negedge clk);
        din = 8'hC3;
        start = 1;
        dv = 1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 0;
            dv = 0;
        end
        checks++;
        if ({cs_n, busy} !== 2'b01) begin
            errors++;
            $display("FAIL rst_mid pre cs_n/busy got %b required 01", {cs_n, busy});
        end
        rst_n = 0;
        #1;
        checks++;
        if ({cs_n, sclk, busy} !== 3'b100) begin
            errors++;
            $display("FAIL rst_mid cs_n/sclk/busy got %b required 100", {cs_n, sclk, busy});
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid done got %b required 0", done);
            end
        end
        rst_n = 1;
        @(negedge clk);
        frame(0, 8'h3C, 8'h3C, 2, 0, 0, "post_rst");
        settle();
    endtask
    initial begin
        test_reset();
        frame(0, 8'h01, 8'h01, 2, 0, 0, "msb_first");
        settle();
        frame(1, 8'h01, 8'h80, 2, 0, 0, "lsb_first");
        settle();
        test_invalid();
        settle();
        frame(2, 8'hA5, 8'hA5, 1, 10, 30, "overrun");
        settle();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/count_serializer.md
Name: count_serializer

Overview:
Downstream consumer of the 8-bit counter stage. On request it snapshots the counter value, then shifts it out on a 3-wire serial link (cs_n, sclk, sdo), SPI mode 0, at a parameterised bit rate. Lets the chip report the count over fewer pins than the parallel uo_out bus. Gives busy/done status and a sticky overrun flag.

Parameters:
WIDTH, 8, bits per frame; equals the counter width.
DIV, 2, clk cycles per sclk half-period; legal range 1..255.
MSB_FIRST, 1, 1 = shift MSB first, 0 = shift LSB first.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  frame request, sampled every cycle
data_valid  input  1  counter output enable; a request is accepted only when high
data_in  input  WIDTH  counter value (q)
clr_ovr  input  1  synchronous clear of ovr
cs_n  output  1  frame select, active low
sclk  output  1  serial clock, idles low
sdo  output  1  serial data
busy  output  1  frame in progress
done  output  1  one-cycle pulse at end of frame
ovr  output  1  sticky: request dropped while busy

Behaviour:
- Reset, asynchronous, all registered outputs: cs_n=1, sclk=0, sdo=0, busy=0, done=0, ovr=0, state=IDLE, shift register=0, divider=0, bit count=0.
- States: IDLE, SHIFT, GAP.
- IDLE -> SHIFT when start=1 and data_valid=1 at edge T0.
  - data_in is captured at T0.
  - From T0+1: cs_n=0, busy=1, sdo = first bit (MSB if MSB_FIRST, else LSB), sclk=0.
- IDLE with start=1 and data_valid=0: request ignored. No state change, ovr unchanged.
- Timing in SHIFT: a divider counts DIV cycles per half-bit.
  - sclk rises DIV cycles after each data change.
  - sclk falls DIV cycles after each rise.
  - On every fall except the last, sdo advances to the next bit.
  - Each bit lasts 2*DIV cycles, so cs_n stays low for exactly 2*DIV*WIDTH cycles.
- SHIFT -> GAP on the last falling edge, at T0+1+2*DIV*WIDTH.
  - That cycle: cs_n=1, sdo=0, sclk=0.
- GAP lasts DIV cycles. GAP -> IDLE at T0+1+2*DIV*WIDTH+DIV.
  - That cycle: done=1 for one cycle and busy=0.
  - A new start is accepted on this same cycle.
- start=1 while busy=1: the request is dropped, ovr set to 1 on the next edge, and the current frame is unaffected. data_in changes during a frame are ignored, because the snapshot is held.
- clr_ovr=1 clears ovr on the next edge. If a drop happens in the same cycle, the set wins and ovr=1.
- Reset asserted mid-frame: outputs return to reset values immediately (cs_n=1, sclk=0). No done pulse. The frame is abandoned.
- data_valid dropping mid-frame has no effect on the frame.
- Divider and bit counter are sized for DIV=255, WIDTH=8 with no wrap. The bit counter covers 0..WIDTH-1 exactly.

Test Plan:
- Reset, then DIV=2, data_in=0x01, start+data_valid pulse at T0 -> MSB_FIRST=1: sdo sampled on sclk rises = 0,0,0,0,0,0,0,1; cs_n low cycles T0+1..T0+32; done=1 only at T0+35.
- Same stimulus with MSB_FIRST=0 -> sdo on rises = 1,0,0,0,0,0,0,0; same cs_n/done timing.
- start with data_valid=0 -> cs_n stays 1, busy 0, ovr 0 for 40 cycles.
- DIV=1, data 0xA5, second start at T0+10 -> 0xA5 sent unchanged (1,0,1,0,0,1,0,1); ovr=1 from T0+11; clr_ovr at T0+30 -> ovr=0 at T0+31.
- start held high continuously with data_valid=1, DIV=1 -> back-to-back frames, each new cs_n fall one cycle after the previous done; ovr=1 (requests during busy).
- rst_n low at T0+12 during frame -> cs_n=1, sclk=0, busy=0 combinationally; after release, a fresh start sends a full correct frame.
